// File: rtl/led_sw_pkg.sv
// Shared types and default parameters for the switch-to-LED controller.
package led_sw_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  localparam int unsigned DEB_CYCLES_DEF      = 16;
  localparam int unsigned BLINK_HALF_DEF      = 8;
  localparam int unsigned AUTO_OFF_CYCLES_DEF = 64;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debounce counter for one slide switch.
// press pulses on the edge where the debounced level rises.
module sw_debounce
  import led_sw_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_db,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          db_q;
  logic          sw_s;
  logic          flip;

  assign sw_s  = sync_q[1];
  assign flip  = (sw_s != db_q) && (cnt_q == CNT_MAX);
  assign press = flip && !db_q;
  assign sw_db = db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_raw};
      if (sw_s == db_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        db_q  <= ~db_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_sw_ctrl.sv
// Switch-to-LED controller: debounced press cycles OFF -> ON -> BLINK -> OFF.
// Optional idle auto-off enabled by defining LED_SW_CTRL_AUTO_OFF_EN.
module led_sw_ctrl
  import led_sw_pkg::*;
#(
  parameter int unsigned DEB_CYCLES      = DEB_CYCLES_DEF,
  parameter int unsigned BLINK_HALF      = BLINK_HALF_DEF,
  parameter int unsigned AUTO_OFF_CYCLES = AUTO_OFF_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:1] sw,
  output logic [1:1] ld,
  output logic       sw_db,
  output logic [1:0] mode
);

  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  logic          press;
  logic          expire;
  mode_e         mode_q;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
  logic          ld_q;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_raw(sw[1]),
    .sw_db (sw_db),
    .press (press)
  );

`ifdef LED_SW_CTRL_AUTO_OFF_EN
  localparam int unsigned TW = (AUTO_OFF_CYCLES > 1) ? $clog2(AUTO_OFF_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(AUTO_OFF_CYCLES - 1);
  logic [TW-1:0] timer_q;
  // A press on the expiry edge wins over the timeout.
  assign expire = (mode_q != MODE_OFF) && (timer_q == TIMER_MAX) && !press;
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      ld_q        <= 1'b0;
`ifdef LED_SW_CTRL_AUTO_OFF_EN
      timer_q     <= '0;
`endif
    end else begin
      ld_q <= (mode_q == MODE_ON) || ((mode_q == MODE_BLINK) && phase_q);
      if (press) begin
        blink_cnt_q <= '0;
        case (mode_q)
          MODE_OFF: begin
            mode_q  <= MODE_ON;
            phase_q <= 1'b0;
          end
          MODE_ON: begin
            mode_q  <= MODE_BLINK;
            phase_q <= 1'b1;
          end
          default: begin
            mode_q  <= MODE_OFF;
            phase_q <= 1'b0;
          end
        endcase
      end else if (expire) begin
        mode_q      <= MODE_OFF;
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (mode_q == MODE_BLINK) begin
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end else begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end
`ifdef LED_SW_CTRL_AUTO_OFF_EN
      if (press || expire || (mode_q == MODE_OFF)) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TW'(1);
      end
`endif
    end
  end

  assign ld[1] = ld_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_led_sw_ctrl.sv
// Directed bench for led_sw_ctrl with DEB_CYCLES=4, BLINK_HALF=3, AUTO_OFF_CYCLES=20.
module tb_led_sw_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:1] sw;
  logic [1:1] ld;
  logic       sw_db;
  logic [1:0] mode;

  int n_vec;
  int n_err;

  led_sw_ctrl #(
    .DEB_CYCLES     (4),
    .BLINK_HALF     (3),
    .AUTO_OFF_CYCLES(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .ld   (ld),
    .sw_db(sw_db),
    .mode (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sw    = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  // Drive sw high; mode changes on the 6th edge.
  task automatic press_to_mode();
    sw = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = 1'b1;
    tick(3);
    n_vec++;
    if ({ld, sw_db, mode} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: ld/sw_db/mode got %b expected 0000", {ld, sw_db, mode});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    n_vec++;
    if ({ld, sw_db, mode} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_edge5: ld/sw_db/mode got %b expected 0000", {ld, sw_db, mode});
    end
    tick(1);
    n_vec++;
    if ({ld, sw_db, mode} !== 4'b0101) begin
      n_err++;
      $display("FAIL reset_edge6: ld/sw_db/mode got %b expected 0101", {ld, sw_db, mode});
    end
    tick(1);
    n_vec++;
    if (ld !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ld_on: ld got %b expected 1", ld);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    sw = 1'b1;
    tick(3);
    sw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_vec++;
      if ({ld, sw_db, mode} !== 4'b0000) begin
        n_err++;
        $display("FAIL glitch[%0d]: ld/sw_db/mode got %b expected 0000", i, {ld, sw_db, mode});
      end
    end
  endtask

  task automatic test_mode_seq();
    logic exp_ld;
    apply_reset();
    press_to_mode();
    n_vec++;
    if (mode !== 2'd1) begin
      n_err++;
      $display("FAIL seq_press1: mode got %0d expected 1", mode);
    end
    tick(4);
    sw = 1'b0;
    tick(10);
    n_vec++;
    if ({ld, mode} !== 3'b101) begin
      n_err++;
      $display("FAIL seq_on_hold: ld/mode got %b expected 101", {ld, mode});
    end
    press_to_mode();
    n_vec++;
    if (mode !== 2'd2) begin
      n_err++;
      $display("FAIL seq_press2: mode got %0d expected 2", mode);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (i == 3) sw = 1'b0;
      exp_ld = ((i % 6) < 3);
      n_vec++;
      if (ld !== exp_ld) begin
        n_err++;
        $display("FAIL seq_blink[%0d]: ld got %b expected %b", i, ld, exp_ld);
      end
    end
    tick(1);
    press_to_mode();
    n_vec++;
    if (mode !== 2'd0) begin
      n_err++;
      $display("FAIL seq_press3: mode got %0d expected 0", mode);
    end
    tick(1);
    n_vec++;
    if (ld !== 1'b0) begin
      n_err++;
      $display("FAIL seq_off_ld: ld got %b expected 0", ld);
    end
    sw = 1'b0;
    tick(10);
  endtask

  task automatic test_release();
    apply_reset();
    press_to_mode();
    tick(4);
    sw = 1'b0;
    tick(5);
    n_vec++;
    if (sw_db !== 1'b1) begin
      n_err++;
      $display("FAIL release_edge5: sw_db got %b expected 1", sw_db);
    end
    tick(1);
    n_vec++;
    if ({ld, sw_db, mode} !== 4'b1001) begin
      n_err++;
      $display("FAIL release_edge6: ld/sw_db/mode got %b expected 1001", {ld, sw_db, mode});
    end
    tick(3);
    n_vec++;
    if ({ld, mode} !== 3'b101) begin
      n_err++;
      $display("FAIL release_hold: ld/mode got %b expected 101", {ld, mode});
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    press_to_mode();
    tick(4);
    sw = 1'b0;
    tick(10);
    press_to_mode();
    tick(2);
    n_vec++;
    if ({ld, sw_db, mode} !== 4'b1110) begin
      n_err++;
      $display("FAIL async_pre: ld/sw_db/mode got %b expected 1110", {ld, sw_db, mode});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ld, sw_db, mode} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_clear: ld/sw_db/mode got %b expected 0000", {ld, sw_db, mode});
    end
    sw = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

`ifdef LED_SW_CTRL_AUTO_OFF_EN
  task automatic test_auto_off();
    apply_reset();
    press_to_mode();
    tick(19);
    n_vec++;
    if (mode !== 2'd1) begin
      n_err++;
      $display("FAIL auto_edge19: mode got %0d expected 1", mode);
    end
    tick(1);
    n_vec++;
    if (mode !== 2'd0) begin
      n_err++;
      $display("FAIL auto_edge20: mode got %0d expected 0", mode);
    end
    // Second run: a press lands exactly on the expiry edge.
    apply_reset();
    press_to_mode();
    tick(4);
    sw = 1'b0;
    tick(10);
    sw = 1'b1;
    tick(5);
    n_vec++;
    if (mode !== 2'd1) begin
      n_err++;
      $display("FAIL auto_press_pre: mode got %0d expected 1", mode);
    end
    tick(1);
    n_vec++;
    if (mode !== 2'd2) begin
      n_err++;
      $display("FAIL auto_press_wins: mode got %0d expected 2", mode);
    end
    tick(19);
    n_vec++;
    if (mode !== 2'd2) begin
      n_err++;
      $display("FAIL auto_timer_cleared: mode got %0d expected 2", mode);
    end
    tick(1);
    n_vec++;
    if (mode !== 2'd0) begin
      n_err++;
      $display("FAIL auto_blink_off: mode got %0d expected 0", mode);
    end
    sw = 1'b0;
    tick(10);
  endtask
`else
  task automatic test_no_auto_off();
    apply_reset();
    press_to_mode();
    tick(40);
    n_vec++;
    if ({ld, mode} !== 3'b101) begin
      n_err++;
      $display("FAIL no_auto_off: ld/mode got %b expected 101", {ld, mode});
    end
    sw = 1'b0;
    tick(10);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sw    = 1'b0;
    test_reset();
    test_glitch();
    test_mode_seq();
    test_release();
    test_async_reset();
`ifdef LED_SW_CTRL_AUTO_OFF_EN
    test_auto_off();
`else
    test_no_auto_off();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
